// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes ALU op and operands, holds them in a
// two-entry skid buffer (main drives the outputs, skid absorbs one stall).
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     alu_control,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [4:0]      shamt,
    output logic [4:0]      rd_addr,
    output logic            illegal
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [3:0]      ctrl;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [4:0]      shamt;
        logic [4:0]      rd;
        logic            illegal;
    } bundle_t;

    bundle_t dec;
    bundle_t main_q;
    bundle_t skid_q;
    logic    main_valid;
    logic    skid_valid;
    logic    in_ready_q;
    logic    in_fire;
    logic    bad;

    wire [6:0] opcode = instr[6:0];
    wire [2:0] f3     = instr[14:12];
    wire [6:0] f7     = instr[31:25];
    wire       r_type = (opcode == OPC_OP);

    // NOTE: every field gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        dec       = '0;
        dec.rd    = instr[11:7];
        bad       = 1'b0;
        unique case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec.op1   = rs1_data;
                dec.op2   = r_type ? rs2_data : {{(XLEN-12){instr[31]}}, instr[31:20]};
                dec.shamt = r_type ? rs2_data[4:0] : instr[24:20];
                // Immediate forms only constrain f7 on the shifts.
                unique case (f3)
                    3'b000: begin
                        dec.ctrl = (r_type && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        bad      = r_type && !(f7 == F7_ZERO || f7 == F7_ALT);
                    end
                    3'b001: begin dec.ctrl = ALU_SLL;  bad = (f7 != F7_ZERO);           end
                    3'b010: begin dec.ctrl = ALU_SLT;  bad = r_type && (f7 != F7_ZERO); end
                    3'b011: begin dec.ctrl = ALU_SLTU; bad = r_type && (f7 != F7_ZERO); end
                    3'b100: begin dec.ctrl = ALU_XOR;  bad = r_type && (f7 != F7_ZERO); end
                    3'b110: begin dec.ctrl = ALU_OR;   bad = r_type && (f7 != F7_ZERO); end
                    3'b111: begin dec.ctrl = ALU_AND;  bad = r_type && (f7 != F7_ZERO); end
                    default: begin
                        dec.ctrl = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        bad      = !(f7 == F7_ZERO || f7 == F7_ALT);
                    end
                endcase
            end
            OPC_LUI: begin
                dec.ctrl = ALU_ADD;
                dec.op2  = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec.ctrl = ALU_ADD;
                dec.op1  = pc;
                dec.op2  = {instr[31:12], 12'b0};
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec.ctrl    = ALU_ADD;
            dec.op1     = '0;
            dec.op2     = '0;
            dec.shamt   = '0;
            dec.illegal = 1'b1;
        end
    end

    assign in_fire = in_valid && in_ready_q;

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values and the block is order-independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            if (!main_valid || out_ready) begin
                // Main frees up: refill from skid first to keep order.
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (in_fire) begin
                    main_q     <= dec;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (in_fire) begin
                skid_valid <= 1'b1;
            end
            in_ready_q <= !(main_valid && !out_ready && (skid_valid || in_fire));
        end
    end

    // NOTE: the skid payload is not reset; skid_valid alone says whether it
    // holds anything, so resetting the data would only cost reset routing.
    always_ff @(posedge clk) begin
        if (!flush && main_valid && !out_ready && in_fire)
            skid_q <= dec;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid;
    assign alu_control = {28'b0, main_q.ctrl};
    assign operand1    = main_q.op1;
    assign operand2    = main_q.op2;
    assign shamt       = main_q.shamt;
    assign rd_addr     = main_q.rd;
    assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure ordering,
// flush and asynchronous reset, checked at the falling edge.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_control;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  shamt;
    logic [4:0]  rd_addr;
    logic        illegal;

    int vectors  = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .operand1(operand1), .operand2(operand2),
        .shamt(shamt), .rd_addr(rd_addr), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
    endtask

    logic [31:0] tags [4];
    logic [31:0] rx [$];
    int          sent;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        tags[0] = 32'hA; tags[1] = 32'hB; tags[2] = 32'hC; tags[3] = 32'hD;

        repeat (2) @(negedge clk);
        check("reset in_ready", {31'b0, in_ready}, 32'd0);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset alu_control", alu_control, 32'd0);
        check("reset operand1", operand1, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", {31'b0, in_ready}, 32'd1);

        // Decode vectors, one per cycle with out_ready held high.
        out_ready = 1'b1;
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);                 // ADD x3,x1,x2
        @(negedge clk);
        check("add out_valid", {31'b0, out_valid}, 32'd1);
        check("add ctrl", alu_control, 32'd0);
        check("add op1", operand1, 32'd5);
        check("add op2", operand2, 32'd7);
        check("add rd", {27'b0, rd_addr}, 32'd3);
        check("add illegal", {31'b0, illegal}, 32'd0);
        drive(32'h402081B3, 32'h0, 32'd5, 32'd7);                 // SUB x3,x1,x2
        @(negedge clk);
        check("sub ctrl", alu_control, 32'd1);
        drive(32'h40735293, 32'h0, 32'h80000000, 32'd3);          // SRAI x5,x6,7
        @(negedge clk);
        check("srai ctrl", alu_control, 32'd9);
        check("srai shamt", {27'b0, shamt}, 32'd7);
        check("srai rd", {27'b0, rd_addr}, 32'd5);
        check("srai op1", operand1, 32'h80000000);
        check("srai op2", operand2, 32'h00000407);
        drive(32'hFFF00093, 32'h0, 32'd0, 32'd9);                 // ADDI x1,x0,-1
        @(negedge clk);
        check("addi ctrl", alu_control, 32'd0);
        check("addi op2", operand2, 32'hFFFFFFFF);
        drive(32'h12345137, 32'h0, 32'd44, 32'd9);                // LUI x2,0x12345
        @(negedge clk);
        check("lui op1", operand1, 32'd0);
        check("lui op2", operand2, 32'h12345000);
        check("lui rd", {27'b0, rd_addr}, 32'd2);
        drive(32'h12345117, 32'h00001000, 32'd44, 32'd9);         // AUIPC x2,0x12345
        @(negedge clk);
        check("auipc op1", operand1, 32'h00001000);
        check("auipc op2", operand2, 32'h12345000);
        drive(32'h0020E1B3, 32'h0, 32'd1, 32'd2);                 // OR x3,x1,x2
        @(negedge clk);
        check("or ctrl", alu_control, 32'd3);
        drive(32'h002091B3, 32'h0, 32'd1, 32'h00000027);          // SLL x3,x1,x2
        @(negedge clk);
        check("sll ctrl", alu_control, 32'd7);
        check("sll shamt", {27'b0, shamt}, 32'd7);
        drive(32'h0000007F, 32'h0, 32'd5, 32'd7);                 // bad opcode
        @(negedge clk);
        check("illegal op flag", {31'b0, illegal}, 32'd1);
        check("illegal op ctrl", alu_control, 32'd0);
        check("illegal op op1", operand1, 32'd0);
        check("illegal op op2", operand2, 32'd0);
        drive(32'h802081B3, 32'h0, 32'd5, 32'd7);                 // bad f7
        @(negedge clk);
        check("illegal f7 flag", {31'b0, illegal}, 32'd1);
        check("illegal f7 op1", operand1, 32'd0);
        check("illegal f7 op2", operand2, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("idle out_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: A..D back to back, out_ready low for two cycles once A shows.
        sent = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid  = (sent < 4);
            instr     = 32'h002081B3;
            rs1_data  = tags[(sent < 4) ? sent : 0];
            rs2_data  = 32'd0;
            out_ready = !(cyc == 1 || cyc == 2);
            if (cyc == 2 || cyc == 3) begin
                check("stall in_ready", {31'b0, in_ready}, 32'd0);
                check("stall out_valid", {31'b0, out_valid}, 32'd1);
                check("stall holds A", operand1, tags[0]);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) rx.push_back(operand1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream sent", sent, 32'd4);
        check("stream received", rx.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("stream order %0d", i), (i < rx.size()) ? rx[i] : 32'hDEAD_BEEF, tags[i]);

        // Flush with both entries occupied and a bundle on the input.
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'hE0, 32'd0);
        @(negedge clk);
        drive(32'h002081B3, 32'h0, 32'hF0, 32'd0);
        @(negedge clk);
        check("full in_ready", {31'b0, in_ready}, 32'd0);
        flush = 1'b1;
        drive(32'h002081B3, 32'h0, 32'h99, 32'd0);
        @(negedge clk);
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        check("flush in_ready", {31'b0, in_ready}, 32'd1);
        drive(32'h002081B3, 32'h0, 32'h77, 32'd0);                // accepted handshake, still dropped
        @(negedge clk);
        check("flush drops input", {31'b0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("no stale 1", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("no stale 2", {31'b0, out_valid}, 32'd0);
        drive(32'h002081B3, 32'h0, 32'h55, 32'd0);
        @(negedge clk);
        check("post flush valid", {31'b0, out_valid}, 32'd1);
        check("post flush op1", operand1, 32'h55);

        // Asynchronous reset mid-stream with a bundle held on the outputs.
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'h66, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst in_ready", {31'b0, in_ready}, 32'd0);
        check("async rst op1", operand1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("release in_ready", {31'b0, in_ready}, 32'd1);
        check("release out_valid", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
